// File: rtl/hazard_stall_ctrl_if.sv
// Decoder-to-interlock bundle for the ID stage of the 6-stage pipeline.
// The master side (decoder) drives the decoded ID instruction; the slave
// side (hazard_stall_ctrl) returns the pipeline enables and the perf counter.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             issue;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, issue, stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd,
        output pc_en, ifid_en, ifid_flush, idex_bubble, issue, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Interlock controller at the ID stage. A shift-register scoreboard holds the
// destination of each instruction in EX..WB; the ID instruction is held while
// any of its sources is still being produced (no forwarding). Jumps flush the
// single wrong-path fetch. A saturating counter records stall cycles.
module hazard_stall_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       valid;
        logic [4:0] rgn;
    } slot_t;

    // slot 0 = EX, slot DEPTH-1 = WB
    slot_t            r_slots [DEPTH];
    logic [CNT_W-1:0] r_stall_count;

    logic       w_use_rs;
    logic       w_use_rt;
    logic [4:0] w_dst;
    logic       w_hazard;
    logic       w_stall;
    logic       w_issue;

    // Decode which fields are real sources and which is the destination;
    // register 0 is never either, so a zero field simply drops out.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_dst    = 5'd0;
        case (bus.id_opcode)
            OP_RTYPE: begin
                w_use_rs = (bus.id_rs != 5'd0);
                w_use_rt = (bus.id_rt != 5'd0);
                w_dst    = bus.id_rd;
            end
            OP_LW, OP_XORI: begin
                w_use_rs = (bus.id_rs != 5'd0);
                w_dst    = bus.id_rt;
            end
            OP_SW: begin
                w_use_rs = (bus.id_rs != 5'd0);
                w_use_rt = (bus.id_rt != 5'd0);
            end
            default: ;
        endcase
    end

    // Compare sources against EX..MEM2 slots; WB is excluded because the
    // register file writes before it reads.
    always_comb begin
        w_hazard = 1'b0;
        if (bus.id_valid) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                if (r_slots[k].valid) begin
                    if (w_use_rs && (r_slots[k].rgn == bus.id_rs)) w_hazard = 1'b1;
                    if (w_use_rt && (r_slots[k].rgn == bus.id_rt)) w_hazard = 1'b1;
                end
            end
        end
    end

    assign w_stall = w_hazard;
    // Nothing issues while reset is held, even if the decoder shows a valid word.
    assign w_issue = bus.id_valid && !w_stall && !rst;

    assign bus.pc_en       = !w_stall;
    assign bus.ifid_en     = !w_stall;
    assign bus.idex_bubble = w_stall;
    assign bus.issue       = w_issue;
    assign bus.ifid_flush  = w_issue && (bus.id_opcode == OP_J);
    assign bus.stall_count = r_stall_count;

    // Advance the scoreboard one stage per clock; a stalled or empty ID
    // pushes an invalid entry so older producers keep draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the scoreboard is control state, so every slot is reset; stale valid bits would stall.
            for (int k = 0; k < DEPTH; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every slot shifts from its pre-edge neighbour.
            for (int k = 1; k < DEPTH; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
            if (w_issue && (w_dst != 5'd0)) begin
                r_slots[0] <= slot_t'{valid: 1'b1, rgn: w_dst};
            end else begin
                r_slots[0] <= '0;
            end
        end
    end

    // Count stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, reset/saturation
// sequences, then random traffic against a register-age reference model.
module tb_hazard_stall_ctrl;

    localparam int DEPTH = 4;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_XOR = 6'b001110;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_NOP = 6'b111111;

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       st;
        logic       fl;
        logic       is;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // Reference model: cycle at which each register's latest producer issued.
    int   cyc;
    int   last_issue [32];
    int   exp_stalls;

    hazard_stall_ctrl_if #(.CNT_W(16)) mif ();
    hazard_stall_ctrl_if #(.CNT_W(4))  sif ();

    hazard_stall_ctrl #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    hazard_stall_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    assign sif.id_valid  = mif.id_valid;
    assign sif.id_opcode = mif.id_opcode;
    assign sif.id_rs     = mif.id_rs;
    assign sif.id_rt     = mif.id_rt;
    assign sif.id_rd     = mif.id_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void decode(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                                   output logic [4:0] s1, s2, d);
        s1 = 5'd0; s2 = 5'd0; d = 5'd0;
        case (op)
            OP_R:          begin s1 = rs; s2 = rt; d = rd; end
            OP_LW, OP_XOR: begin s1 = rs; d = rt; end
            OP_SW:         begin s1 = rs; s2 = rt; end
            default: ;
        endcase
    endfunction

    // A source is pending if its producer issued fewer than DEPTH cycles ago.
    function automatic logic model_stall(input logic v, input logic [5:0] op,
                                         input logic [4:0] rs, rt, rd);
        logic [4:0] s1, s2, d;
        decode(op, rs, rt, rd, s1, s2, d);
        if (!v) return 1'b0;
        if (s1 != 5'd0 && (cyc - last_issue[s1]) < DEPTH) return 1'b1;
        if (s2 != 5'd0 && (cyc - last_issue[s2]) < DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) last_issue[r] = -100;
        exp_stalls = 0;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd);
        mif.id_valid  = v;
        mif.id_opcode = op;
        mif.id_rs     = rs;
        mif.id_rt     = rt;
        mif.id_rd     = rd;
    endtask

    task automatic check_counts();
        check("stall_count", 32'(mif.stall_count), (exp_stalls > 65535) ? 65535 : exp_stalls);
        check("stall_count_sat4", 32'(sif.stall_count), (exp_stalls > 15) ? 15 : exp_stalls);
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance model.
    task automatic apply(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                         input logic es, ef, ei);
        logic [4:0] s1, s2, d;
        drive(v, op, rs, rt, rd);
        @(negedge clk);
        check("pc_en",       32'(mif.pc_en),       32'(!es));
        check("ifid_en",     32'(mif.ifid_en),     32'(!es));
        check("idex_bubble", 32'(mif.idex_bubble), 32'(es));
        check("issue",       32'(mif.issue),       32'(ei));
        check("ifid_flush",  32'(mif.ifid_flush),  32'(ef));
        check_counts();
        @(posedge clk);
        #1;
        decode(op, rs, rt, rd, s1, s2, d);
        if (ei && d != 5'd0) last_issue[d] = cyc;
        if (es) exp_stalls++;
        cyc++;
    endtask

    task automatic apply_vec(input vec_t t);
        apply(t.v, t.op, t.rs, t.rt, t.rd, t.st, t.fl, t.is);
    endtask

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                                input logic st, fl, is);
        vec_t t;
        t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd;
        t.st = st; t.fl = fl; t.is = is;
        return t;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl [$];

    initial begin
        logic [5:0] ops [6];
        logic       v, es, ei, ef;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        model_reset();
        ops = '{OP_R, OP_LW, OP_XOR, OP_SW, OP_J, OP_NOP};

        // lw $2 ; add $3,$2,$4 back-to-back: 3 stalls then issue
        tbl.push_back(mk(1, OP_LW, 1, 2, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_R, 2, 4, 3, 1, 0, 0));
        tbl.push_back(mk(1, OP_R, 2, 4, 3, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // lw $2 ; xori $5,$6,1 ; add $3,$2,$4: xori free, add stalls 2
        tbl.push_back(mk(1, OP_LW, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, OP_XOR, 6, 5, 0, 0, 0, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, OP_R, 2, 4, 3, 1, 0, 0));
        tbl.push_back(mk(1, OP_R, 2, 4, 3, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // invalid ID word in the gap: never stalls, never issues
        tbl.push_back(mk(1, OP_LW, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, OP_R, 2, 4, 3, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, OP_R, 2, 4, 3, 1, 0, 0));
        tbl.push_back(mk(1, OP_R, 2, 4, 3, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // add $0,$1,$2 ; sw $0,4($0): $0 never a dependency
        tbl.push_back(mk(1, OP_R, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, OP_SW, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // j: one-cycle flush, no sources, no scoreboard entry
        tbl.push_back(mk(1, OP_J, 7, 7, 7, 0, 1, 1));
        tbl.push_back(mk(1, OP_R, 7, 0, 8, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // add $7 ; sw $7,0($1): rt dependency of a store, 3 bubbles
        tbl.push_back(mk(1, OP_R, 1, 2, 7, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_SW, 1, 7, 0, 1, 0, 0));
        tbl.push_back(mk(1, OP_SW, 1, 7, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // unknown opcode: fields ignored as both sources and destination
        tbl.push_back(mk(1, OP_R, 1, 2, 7, 0, 0, 1));
        tbl.push_back(mk(1, OP_NOP, 7, 7, 9, 0, 0, 1));
        tbl.push_back(mk(1, OP_R, 9, 0, 10, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));
        // two producers of $2: stall follows the younger one
        tbl.push_back(mk(1, OP_LW, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, OP_LW, 3, 2, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_R, 2, 0, 4, 1, 0, 0));
        tbl.push_back(mk(1, OP_R, 2, 0, 4, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0));

        // Reset state, with a valid jump presented while reset is held
        rst = 1'b1;
        drive(1'b1, OP_J, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("rst_pc_en",       32'(mif.pc_en), 1);
        check("rst_ifid_en",     32'(mif.ifid_en), 1);
        check("rst_ifid_flush",  32'(mif.ifid_flush), 0);
        check("rst_idex_bubble", 32'(mif.idex_bubble), 0);
        check("rst_issue",       32'(mif.issue), 0);
        check_counts();
        @(posedge clk);
        #1;
        drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

        // Reset pulse in the second cycle of a 3-cycle stall
        apply(1, OP_LW, 1, 2, 0, 0, 0, 1);
        apply(1, OP_R, 2, 4, 3, 1, 0, 0);
        drive(1'b1, OP_R, 5'd2, 5'd4, 5'd3);
        @(negedge clk);
        check("midstall_bubble", 32'(mif.idex_bubble), 1);
        rst = 1'b1;
        #1;
        check("midrst_pc_en",       32'(mif.pc_en), 1);
        check("midrst_idex_bubble", 32'(mif.idex_bubble), 0);
        check("midrst_issue",       32'(mif.issue), 0);
        check("midrst_stall_count", 32'(mif.stall_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        idle(1);

        // Drive enough stalls to saturate the 4-bit counter instance
        for (int g = 0; g < 6; g++) begin
            apply(1, OP_LW, 1, 2, 0, 0, 0, 1);
            for (int i = 0; i < 3; i++) apply(1, OP_R, 2, 4, 3, 1, 0, 0);
            apply(1, OP_R, 2, 4, 3, 0, 0, 1);
            idle(3);
        end
        check("sat4_final", 32'(sif.stall_count), 15);

        // Random traffic against the register-age model
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            op = ops[$urandom_range(0, 5)];
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            es = model_stall(v, op, rs, rt, rd);
            ei = v && !es;
            ef = ei && (op == OP_J);
            apply(v, op, rs, rt, rd, es, ef, ei);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
